// File: rtl/fetch_decode_queue.sv
// Fetch->decode packet queue: circular FIFO between ifetch and decode.
// A redirect flush empties it so no wrong-path packet reaches decode.
module fetch_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       must_flush,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [PC_W-1:0]            pc_i,
  input  logic [INSTR_W-1:0]         instr_i,
  input  logic                       taken_i,
  input  logic                       invalid_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [PC_W-1:0]            pc_o,
  output logic [INSTR_W-1:0]         instr_o,
  output logic                       taken_o,
  output logic                       invalid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               taken;
    logic               invalid;
  } pkt_t;

  pkt_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  pkt_t          w_head;

  assign w_full  = (r_cnt == CW'(DEPTH));
  // rst_n is active-high here; hold ready low while it is asserted
  assign ready_o = ~rst_n & ~w_full & ~must_flush;
  assign valid_o = (r_cnt != '0) & ~must_flush;
  assign w_push  = valid_i & ready_o;
  assign w_pop   = valid_o & ready_i;

  assign w_head    = r_mem[r_rd];
  assign pc_o      = w_head.pc;
  assign instr_o   = w_head.instr;
  assign taken_o   = w_head.taken;
  assign invalid_o = w_head.invalid;
  assign count_o        = r_cnt;
  assign overflow_err_o = r_ovf;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= '{pc: pc_i, instr: instr_i,
                       taken: taken_i, invalid: invalid_i};
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (must_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  // Diagnostic only: upstream stalls, nothing is lost
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      r_ovf <= 1'b0;
    else if (valid_i && w_full && !must_flush)
      r_ovf <= 1'b1;
  end

endmodule
